// File: rtl/counter_sequencer.sv
// Command sequencer driving an external 4-bit up/down counter: LOAD, CLEAR and multi-step UP/DOWN.
// Optional SEQ_ABORT_EN adds an abort input and an aborted flag on the completion pulse.
module counter_sequencer (
    input  logic       clk,
    input  logic       mr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_arg,
    output logic       cnt_mr,
    output logic       cnt_load,
    output logic       cnt_en,
    output logic       cnt_dn,
    output logic [3:0] cnt_d,
    input  logic [3:0] cnt_q,
    output logic       busy,
    output logic       done,
    output logic [3:0] wrap_cnt,
    output logic [3:0] result_q
`ifdef SEQ_ABORT_EN
    ,
    input  logic       abort,
    output logic       aborted
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] op_r;
    logic [3:0] arg_r;
    logic [3:0] rem;
    logic       accept;
    logic       abort_hit;
    logic       wrap_evt;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef SEQ_ABORT_EN
    logic aborted_r;
    assign abort_hit = abort & ((state == S_LOAD) | (state == S_RUN));
    assign aborted   = (state == S_DONE) & aborted_r;

    always_ff @(posedge clk) begin
        if (mr) begin
            aborted_r <= 1'b0;
        end else if (accept) begin
            aborted_r <= 1'b0;
        end else if (abort_hit) begin
            aborted_r <= 1'b1;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    // mr also clears the counter so an aborted-by-reset RUN leaves it at zero
    assign cnt_mr    = mr | (state == S_CLEAR);
    assign cnt_load  = (state == S_LOAD) & ~abort_hit;
    assign cnt_d     = (state == S_LOAD) ? arg_r : 4'd0;
    assign cnt_en    = (state == S_RUN) & ~abort_hit;
    assign cnt_dn    = (state == S_RUN) & (op_r == OP_DOWN);
    assign wrap_evt  = cnt_en & (((op_r == OP_UP)   & (cnt_q == 4'hF)) |
                                 ((op_r == OP_DOWN) & (cnt_q == 4'h0)));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD:  state_nxt = S_LOAD;
                        OP_CLEAR: state_nxt = S_CLEAR;
                        default:  state_nxt = (cmd_arg == 4'd0) ? S_DONE : S_RUN;
                    endcase
                end
            end
            S_LOAD:  state_nxt = S_DONE;
            S_CLEAR: state_nxt = S_DONE;
            S_RUN:   if (abort_hit || rem == 4'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mr) begin
            state    <= S_IDLE;
            rem      <= 4'd0;
            wrap_cnt <= 4'd0;
            result_q <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem      <= cmd_arg;
                wrap_cnt <= 4'd0;
            end else if (state == S_RUN) begin
                rem <= rem - 4'd1;
                if (wrap_evt) wrap_cnt <= sat_inc4(wrap_cnt);
            end
            if (state == S_DONE) result_q <= cnt_q;
        end
    end

    // command operands are plain data: captured on accept, never reset
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= cmd_op;
            arg_r <= cmd_arg;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural 4-bit counter closes the loop on cnt_q;
// table vectors, directed corner sequences and random commands against a reference model.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       mr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       cnt_mr, cnt_load, cnt_en, cnt_dn;
    logic [3:0] cnt_d;
    logic [3:0] cnt_q;
    logic       busy, done;
    logic [3:0] wrap_cnt, result_q;
    logic       abort;
    logic       aborted;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    counter_sequencer dut (
        .clk(clk), .mr(mr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_mr(cnt_mr), .cnt_load(cnt_load),
        .cnt_en(cnt_en), .cnt_dn(cnt_dn), .cnt_d(cnt_d), .cnt_q(cnt_q),
        .busy(busy), .done(done), .wrap_cnt(wrap_cnt), .result_q(result_q)
`ifdef SEQ_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

`ifndef SEQ_ABORT_EN
    assign aborted = 1'b0;
`endif

    // external 4-bit up/down counter
    logic [3:0] q_ext;
    always_ff @(posedge clk) begin
        if (cnt_mr)        q_ext <= 4'd0;
        else if (cnt_load) q_ext <= cnt_d;
        else if (cnt_en)   q_ext <= cnt_dn ? q_ext - 4'd1 : q_ext + 4'd1;
    end
    assign cnt_q = q_ext;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: effect of one command on a counter value, from the command rules
    task automatic model_cmd(input logic [1:0] op, input int arg, inout int q,
                             output int lat, output int res, output int wr);
        wr = 0;
        case (op)
            2'b00: begin q = arg; lat = 2; end
            2'b11: begin q = 0; lat = 2; end
            2'b01: begin
                for (int k = 0; k < arg; k++) if ((q + k) % 16 == 15) wr++;
                q = (q + arg) % 16;
                lat = (arg == 0) ? 1 : arg + 1;
            end
            default: begin
                for (int k = 0; k < arg; k++) if (((q - k) % 16 + 16) % 16 == 0) wr++;
                q = ((q - arg) % 16 + 16) % 16;
                lat = (arg == 0) ? 1 : arg + 1;
            end
        endcase
        if (wr > 15) wr = 15;
        res = q;
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] arg,
                           input int exp_lat, input int exp_res, input int exp_wrap);
        int lat, en_n, ld_n, bad_d, bad_dn;
        bit got;
        @(negedge clk);
        chk({name, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; en_n = 0; ld_n = 0; bad_d = 0; bad_dn = 0; got = 0;
        while (!got && lat < 40) begin
            lat++;
            if (cnt_en) begin
                en_n++;
                if (cnt_dn != (op == 2'b10)) bad_dn++;
            end
            if (cnt_load) begin
                ld_n++;
                if (cnt_d != arg) bad_d++;
            end else if (cnt_d != 4'd0) bad_d++;
            if (done) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk({name, " done_seen"}, int'(got), 1);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " en_cycles"}, en_n, (op == 2'b01 || op == 2'b10) ? int'(arg) : 0);
        chk({name, " load_cycles"}, ld_n, (op == 2'b00) ? 1 : 0);
        chk({name, " cnt_d/cnt_dn errors"}, bad_d + bad_dn, 0);
        chk({name, " aborted"}, aborted, 0);
        @(posedge clk); #1;
        chk({name, " result_q"}, result_q, exp_res);
        chk({name, " wrap_cnt"}, wrap_cnt, exp_wrap);
        chk({name, " done_low"}, done, 0);
        chk({name, " idle"}, busy, 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] arg;
        int         lat;
        int         res;
        int         wrap;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int mq, lat, res, wr, acc_n, done_n, en_n;
        logic [1:0] rop;
        logic [3:0] rarg;

        tbl[0] = '{2'b00, 4'd9,  2,  9,   0};
        tbl[1] = '{2'b00, 4'hE,  2,  14,  0};
        tbl[2] = '{2'b01, 4'd3,  4,  1,   1};
        tbl[3] = '{2'b00, 4'd1,  2,  1,   0};
        tbl[4] = '{2'b10, 4'd15, 16, 2,   1};
        tbl[5] = '{2'b01, 4'd0,  1,  2,   0};
        tbl[6] = '{2'b11, 4'd7,  2,  0,   0};
        tbl[7] = '{2'b10, 4'd1,  2,  15,  1};
        tbl[8] = '{2'b01, 4'd1,  2,  0,   1};
        tbl[9] = '{2'b10, 4'd0,  1,  0,   0};

        mr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'd0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cnt_mr", cnt_mr, 1);
        mr = 1'b0;
        #1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cnt_load", cnt_load, 0);
        chk("reset cnt_en", cnt_en, 0);
        chk("reset cnt_dn", cnt_dn, 0);
        chk("reset cnt_d", cnt_d, 0);
        chk("reset cnt_mr released", cnt_mr, 0);
        chk("reset wrap_cnt", wrap_cnt, 0);
        chk("reset result_q", result_q, 0);

        for (int i = 0; i < 10; i++)
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].arg, tbl[i].lat, tbl[i].res, tbl[i].wrap);

        // reset in the 2nd RUN cycle of UP 5
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 4'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mr = 1'b1;
        #1;
        chk("mr cnt_mr during reset", cnt_mr, 1);
        chk("mr busy before edge", busy, 1);
        @(posedge clk); #1;
        mr = 1'b0;
        chk("mr idle busy", busy, 0);
        chk("mr cmd_ready", cmd_ready, 1);
        chk("mr counter cleared", cnt_q, 0);
        chk("mr wrap_cnt", wrap_cnt, 0);
        done_n = 0;
        repeat (5) begin
            if (done) done_n++;
            @(posedge clk); #1;
        end
        chk("mr no done pulse", done_n, 0);

        // cmd_valid held high: one accept per IDLE cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 4'd5;
        acc_n = 0; done_n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc_n++;
            @(posedge clk); #1;
            if (done) done_n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold accepts", acc_n, 3);
        chk("hold done pulses", done_n, 3);
        repeat (2) @(posedge clk);
        #1;
        chk("hold result_q", result_q, 5);
        mq = 5;

`ifdef SEQ_ABORT_EN
        // abort in the 3rd RUN cycle of UP 5 from 5
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 4'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        en_n = 0;
        if (cnt_en) en_n++;
        @(posedge clk); #1;
        if (cnt_en) en_n++;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort cnt_en forced low", cnt_en, 0);
        if (cnt_en) en_n++;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort steps issued", en_n, 2);
        chk("abort done", done, 1);
        chk("abort aborted", aborted, 1);
        @(posedge clk); #1;
        chk("abort result_q", result_q, 7);
        chk("abort wrap_cnt", wrap_cnt, 0);
        chk("abort flag cleared", aborted, 0);
        mq = 7;
`else
        en_n = 0;
`endif

        // randomized commands against the reference model
        for (int i = 0; i < 60; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rarg = 4'($urandom_range(0, 15));
            model_cmd(rop, int'(rarg), mq, lat, res, wr);
            run_cmd($sformatf("rnd%0d op%0d arg%0d", i, rop, rarg), rop, rarg, lat, res, wr);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk (rising edge) and mr (sync, active-high).
REQ-002 The ports SHALL be, clock and reset first:
- clk        in   1  system clock
- mr         in   1  synchronous active-high reset
- cmd_valid  in   1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op     in   2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
- cmd_arg    in   4  LOAD value, or UP/DOWN step count 0-15; ignored for CLEAR
- cnt_mr     out  1  clear strobe to the 4-bit up/down counter
- cnt_load   out  1  load strobe to the counter
- cnt_en     out  1  count enable to the counter
- cnt_dn     out  1  direction to the counter: 0 up, 1 down
- cnt_d      out  4  load data to the counter
- cnt_q      in   4  counter value
- busy       out  1  high in every state except IDLE
- done       out  1  one-cycle completion pulse
- wrap_cnt   out  4  wrap events in the last UP/DOWN command, saturating
- result_q   out  4  cnt_q captured at command completion

Function
REQ-003 The state machine SHALL have states IDLE, LOAD, CLEAR, RUN and DONE.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid&cmd_ready=1; cmd_valid is ignored in every other state.
REQ-005 On accept, the block SHALL latch op and arg, clear wrap_cnt to 0, and go to LOAD (op 00), CLEAR (op 11), RUN (op 01/10 with arg!=0), or DONE (op 01/10 with arg=0).
REQ-006 LOAD SHALL last one cycle with cnt_load=1 and cnt_d=latched arg, then go to DONE.
REQ-007 CLEAR SHALL last one cycle with cnt_mr=1, then go to DONE.
REQ-008 RUN SHALL last exactly arg cycles with cnt_en=1 and cnt_dn=(op==10); a 4-bit remaining-steps register counts down, and the block goes to DONE on the cycle where remaining=1.
REQ-009 A wrap event is a RUN cycle with (UP and cnt_q=4'hF) or (DOWN and cnt_q=4'h0); each event SHALL increment wrap_cnt, saturating at 15.
REQ-010 DONE SHALL last one cycle with done=1, then go to IDLE; result_q SHALL load cnt_q on the edge leaving DONE and hold it until the next completion.
REQ-011 Outside the states above, cnt_load, cnt_en and cnt_dn SHALL be 0 and cnt_d SHALL be 0.
REQ-012 Command latency from the accept edge to done=1 SHALL be: LOAD/CLEAR 2 cycles; UP/DOWN arg+1 cycles; arg=0 1 cycle.
REQ-013 Back-to-back commands SHALL be supported: cmd_ready is high in the cycle after DONE, so throughput is one command per latency+1 cycles.

Reset
REQ-014 While mr=1 at a rising edge, the state SHALL become IDLE and wrap_cnt, result_q and the remaining-steps register SHALL become 0; this takes priority over any command or state in progress.
REQ-015 cnt_mr SHALL equal mr OR (state==CLEAR), so that reset during RUN also clears the counter; the aborted command produces no done pulse.
REQ-016 After reset the outputs SHALL be cmd_ready=1, busy=0, done=0, cnt_load=0, cnt_en=0, cnt_dn=0, cnt_d=0.

Configuration
REQ-017 Macro SEQ_ABORT_EN SHALL be supported:
- Defined: the block adds input abort (1 bit) and output aborted (1 bit). When abort=1 in LOAD or RUN, cnt_load and cnt_en are forced to 0 in that cycle and the next state is DONE; aborted=1 together with that done pulse; wrap_cnt counts only the steps actually issued.
- Undefined: neither port exists and commands always run to completion.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- LOAD arg=9 -> cnt_load=1 for 1 cycle with cnt_d=9; done 2 cycles after accept; result_q=9.
- cnt_q=E, UP arg=3 -> cnt_en high for 3 cycles; cnt_q goes F,0,1; wrap_cnt=1; result_q=1; done at accept+4.
- cnt_q=1, DOWN arg=15 -> 15 enable cycles, wrap_cnt=1, result_q=2.
- UP arg=0 -> no cnt_en; done at accept+1; wrap_cnt=0.
- mr asserted in the 2nd RUN cycle of UP arg=5 -> next cycle IDLE, cnt_mr=1 during reset, no done, cmd_ready=1 after reset.
- cmd_valid held high through busy -> exactly one accept per IDLE cycle; with SEQ_ABORT_EN, abort in the 3rd RUN cycle -> exactly 2 steps issued, done=1 with aborted=1.
